// File: rtl/gray_ptr_rx_if.sv
// Read-side pointer bus of the CDC FIFO: foreign-domain Gray write pointer in,
// read request in, RAM read address, Gray read pointer and status out.
interface gray_ptr_rx_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH:0]   wr_ptr_gray_in;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  underflow;
  logic                  ptr_err;

  modport master (
    output wr_ptr_gray_in, rd_en,
    input  rd_addr, rd_ptr_gray, empty, level, underflow, ptr_err
  );

  modport slave (
    input  wr_ptr_gray_in, rd_en,
    output rd_addr, rd_ptr_gray, empty, level, underflow, ptr_err
  );
endinterface

// File: rtl/gray_ptr_rx.sv
// Read-side pointer stage of the camera CDC FIFO: synchronizes the Gray write
// pointer, keeps the binary read pointer and derives empty/level/underflow.
// Optional pointer-integrity checker enabled by `GRAY_PTR_RX_CHECK_EN.
module gray_ptr_rx #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_ptr_rx_if.slave   bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  logic [PW-1:0] sync_r [SYNC_STAGES];
  logic [PW-1:0] wr_gray_s;
  logic [PW-1:0] wr_ptr_bin_r;
  logic [PW-1:0] rd_ptr_bin_r;
  logic [PW-1:0] rd_ptr_gray_r;
  logic [PW-1:0] next_rd_ptr_bin_s;
  logic [PW-1:0] level_s;
  logic          empty_s;
  logic          rd_acc_s;
  logic          underflow_r;
  logic          ptr_err_s;

  assign wr_gray_s = sync_r[SYNC_STAGES-1];

  // Plain flop chain on the asynchronous Gray pointer, nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= PTR_ZERO;
      end
    end else begin
      sync_r[0] <= bus.wr_ptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Occupancy and read-accept decode from registered pointers.
  always_comb begin
    level_s  = wr_ptr_bin_r - rd_ptr_bin_r;
    empty_s  = (level_s == PTR_ZERO);
    rd_acc_s = bus.rd_en & ~empty_s;
    if (rd_acc_s) begin
      next_rd_ptr_bin_s = rd_ptr_bin_r + PTR_ONE;
    end else begin
      next_rd_ptr_bin_s = rd_ptr_bin_r;
    end
  end

  // Pointer registers; the Gray read pointer is taken from the next binary
  // value so it always matches rd_ptr_bin_r on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_bin_r  <= PTR_ZERO;
      rd_ptr_bin_r  <= PTR_ZERO;
      rd_ptr_gray_r <= PTR_ZERO;
      underflow_r   <= 1'b0;
    end else begin
      wr_ptr_bin_r  <= gray2bin(wr_gray_s);
      rd_ptr_bin_r  <= next_rd_ptr_bin_s;
      rd_ptr_gray_r <= bin2gray(next_rd_ptr_bin_s);
      underflow_r   <= bus.rd_en & empty_s;
    end
  end

`ifdef GRAY_PTR_RX_CHECK_EN
  localparam logic [PW-1:0] LEVEL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic multi_bit(input logic [PW-1:0] d);
    return (d & (d - PTR_ONE)) != PTR_ZERO;
  endfunction

  logic [PW-1:0] wr_gray_prev_r;
  logic          ptr_err_r;
  logic          gray_jump_s;
  logic          level_ovf_s;

  // A legal Gray stream moves at most one bit per sample.
  always_comb begin
    gray_jump_s = multi_bit(wr_gray_s ^ wr_gray_prev_r);
    level_ovf_s = (level_s > LEVEL_MAX);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_gray_prev_r <= PTR_ZERO;
      ptr_err_r      <= 1'b0;
    end else begin
      wr_gray_prev_r <= wr_gray_s;
      if (gray_jump_s || level_ovf_s) begin
        ptr_err_r <= 1'b1;
      end else begin
        ptr_err_r <= ptr_err_r;
      end
    end
  end

  assign ptr_err_s = ptr_err_r;
`else
  assign ptr_err_s = 1'b0;
`endif

  assign bus.rd_addr     = rd_ptr_bin_r[ADDR_WIDTH-1:0];
  assign bus.rd_ptr_gray = rd_ptr_gray_r;
  assign bus.empty       = empty_s;
  assign bus.level       = level_s;
  assign bus.underflow   = underflow_r;
  assign bus.ptr_err     = ptr_err_s;
endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed, table-driven bench for gray_ptr_rx (ADDR_WIDTH=4, SYNC_STAGES=2).
module tb_gray_ptr_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  gray_ptr_rx_if #(.ADDR_WIDTH(4)) bus ();

  gray_ptr_rx #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] wr_gray;
    logic       rd_en;
    logic [3:0] addr;
    logic       empty;
    logic [4:0] level;
    logic       uf;
    logic [4:0] gray;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input logic [3:0] ea, input logic ee,
                       input logic [4:0] el, input logic eu, input logic [4:0] eg);
    n_vec++;
    if (bus.rd_addr !== ea || bus.empty !== ee || bus.level !== el ||
        bus.underflow !== eu || bus.rd_ptr_gray !== eg) begin
      n_err++;
      $display("FAIL %s: got addr=%0d empty=%b level=%0d underflow=%b rd_ptr_gray=%h, want addr=%0d empty=%b level=%0d underflow=%b rd_ptr_gray=%h",
               name, bus.rd_addr, bus.empty, bus.level, bus.underflow, bus.rd_ptr_gray,
               ea, ee, el, eu, eg);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.rd_en = 1'b0;
    bus.wr_ptr_gray_in = 5'h00;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    logic [3:0] acc_addr [4];
    logic [4:0] acc_gray [4];
    logic found;
    logic exp_err;

`ifdef GRAY_PTR_RX_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    //               in     rd    addr   empty lvl    uf    gray
    vecs[0]  = '{5'h01, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 5'h00};
    vecs[1]  = '{5'h03, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 5'h00};
    vecs[2]  = '{5'h02, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 5'h00};
    vecs[3]  = '{5'h06, 1'b0, 4'd0, 1'b0, 5'd1, 1'b0, 5'h00};
    vecs[4]  = '{5'h07, 1'b0, 4'd0, 1'b0, 5'd2, 1'b0, 5'h00};
    vecs[5]  = '{5'h07, 1'b0, 4'd0, 1'b0, 5'd3, 1'b0, 5'h00};
    vecs[6]  = '{5'h07, 1'b0, 4'd0, 1'b0, 5'd4, 1'b0, 5'h00};
    vecs[7]  = '{5'h07, 1'b1, 4'd0, 1'b0, 5'd5, 1'b0, 5'h00};
    vecs[8]  = '{5'h07, 1'b1, 4'd1, 1'b0, 5'd4, 1'b0, 5'h01};
    vecs[9]  = '{5'h07, 1'b1, 4'd2, 1'b0, 5'd3, 1'b0, 5'h03};
    vecs[10] = '{5'h07, 1'b1, 4'd3, 1'b0, 5'd2, 1'b0, 5'h02};
    vecs[11] = '{5'h07, 1'b1, 4'd4, 1'b0, 5'd1, 1'b0, 5'h06};
    vecs[12] = '{5'h07, 1'b1, 4'd5, 1'b1, 5'd0, 1'b0, 5'h07};
    vecs[13] = '{5'h07, 1'b1, 4'd5, 1'b1, 5'd0, 1'b1, 5'h07};
    vecs[14] = '{5'h07, 1'b0, 4'd5, 1'b1, 5'd0, 1'b1, 5'h07};
    vecs[15] = '{5'h05, 1'b0, 4'd5, 1'b1, 5'd0, 1'b0, 5'h07};
    vecs[16] = '{5'h04, 1'b0, 4'd5, 1'b1, 5'd0, 1'b0, 5'h07};
    vecs[17] = '{5'h04, 1'b0, 4'd5, 1'b1, 5'd0, 1'b0, 5'h07};
    vecs[18] = '{5'h04, 1'b1, 4'd5, 1'b0, 5'd1, 1'b0, 5'h07};
    vecs[19] = '{5'h04, 1'b1, 4'd6, 1'b0, 5'd1, 1'b0, 5'h05};
    vecs[20] = '{5'h04, 1'b0, 4'd7, 1'b1, 5'd0, 1'b0, 5'h04};

    // Reset state with a hostile input value and read requests present.
    bus.wr_ptr_gray_in = 5'h1F;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold[%0d]", i), 4'd0, 1'b1, 5'd0, 1'b0, 5'h00);
      check_val($sformatf("reset_ptr_err[%0d]", i), int'(bus.ptr_err), 0);
    end
    bus.wr_ptr_gray_in = 5'h00;
    bus.rd_en = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Fill, drain, last word, underflow and simultaneous write/read.
    for (int i = 0; i < 21; i++) begin
      bus.wr_ptr_gray_in = vecs[i].wr_gray;
      bus.rd_en = vecs[i].rd_en;
      @(negedge clk);
      check($sformatf("fill_drain[%0d]", i), vecs[i].addr, vecs[i].empty,
            vecs[i].level, vecs[i].uf, vecs[i].gray);
      next_cycle();
    end

    // Wrap: preload to pointer 30, then cross 31 -> 0 -> 1.
    do_reset();
    for (int w = 1; w <= 30; w++) begin
      bus.wr_ptr_gray_in = to_gray(w);
      bus.rd_en = 1'b1;
      next_cycle();
    end
    repeat (6) next_cycle();
    bus.rd_en = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("wrap_preload", 4'd14, 1'b1, 5'd0, 1'b0, 5'h11);
    next_cycle();
    acc_n = 0;
    for (int k = 0; k < 10; k++) begin
      bus.wr_ptr_gray_in = (k == 0) ? to_gray(31) : ((k == 1) ? to_gray(0) : to_gray(1));
      bus.rd_en = 1'b1;
      @(negedge clk);
      check_val($sformatf("wrap_level_le3[%0d]", k), int'(bus.level <= 5'd3), 1);
      if (bus.rd_en && !bus.empty) begin
        if (acc_n < 4) begin
          acc_addr[acc_n] = bus.rd_addr;
          acc_gray[acc_n] = bus.rd_ptr_gray;
        end
        acc_n++;
      end
      next_cycle();
    end
    bus.rd_en = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("wrap_final", 4'd1, 1'b1, 5'd0, 1'b0, 5'h01);
    check_val("wrap_read_count", acc_n, 3);
    if (acc_n >= 3) begin
      check_val("wrap_addr0", int'(acc_addr[0]), 14);
      check_val("wrap_addr1", int'(acc_addr[1]), 15);
      check_val("wrap_addr2", int'(acc_addr[2]), 0);
      check_val("wrap_gray0", int'(acc_gray[0]), 'h11);
      check_val("wrap_gray1", int'(acc_gray[1]), 'h10);
      check_val("wrap_gray2", int'(acc_gray[2]), 'h00);
    end
    next_cycle();

    // Asynchronous reset between clock edges at level 7.
    do_reset();
    for (int w = 1; w <= 9; w++) begin
      bus.wr_ptr_gray_in = to_gray(w);
      next_cycle();
    end
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      if (bus.level == 5'd9) found = 1'b1;
      else next_cycle();
    end
    check_val("mid_fill_reached", int'(found), 1);
    next_cycle();
    bus.rd_en = 1'b1;
    repeat (2) next_cycle();
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("mid_level7", 4'd2, 1'b0, 5'd7, 1'b0, 5'h03);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_async_reset", 4'd0, 1'b1, 5'd0, 1'b0, 5'h00);
    check_val("mid_async_ptr_err", int'(bus.ptr_err), 0);
    bus.wr_ptr_gray_in = 5'h00;
    next_cycle();
    rst_n = 1'b1;

    // Two-bit jump on the Gray bus.
    do_reset();
    bus.wr_ptr_gray_in = 5'h03;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("ptr_err_set", int'(bus.ptr_err), int'(exp_err));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("ptr_err_held[%0d]", i), int'(bus.ptr_err), int'(exp_err));
    end
    rst_n = 1'b0;
    #1;
    check_val("ptr_err_reset", int'(bus.ptr_err), 0);
    bus.wr_ptr_gray_in = 5'h00;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Read-side pointer stage of the camera data path's clock-domain-crossing FIFO. It receives the write pointer as a Gray-coded bus from the foreign clock domain and passes it through a multi-flop synchronizer. It then converts the pointer back to binary and maintains the local binary read pointer. From these it derives `empty` and `level` and returns a registered Gray-coded read pointer for the write side. It sits directly downstream of the write-side binary-to-Gray converter and directly upstream of the FIFO RAM read port.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: RAM address width. Pointers are `ADDR_WIDTH+1` bits, with the MSB as the wrap bit.
- `SYNC_STAGES`, default 2: synchronizer depth. Legal range is 2..4.

Ports:
- `clk`  in  1  read-domain clock. All state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Deassertion is synchronous to `clk` and is handled externally.
- `wr_ptr_gray_in`  in  ADDR_WIDTH+1  Gray-coded write pointer, asynchronous to `clk`.
- `rd_en`  in  1  read request.
- `rd_addr`  out  ADDR_WIDTH  RAM read address, equal to `rd_ptr_bin[ADDR_WIDTH-1:0]`.
- `rd_ptr_gray`  out  ADDR_WIDTH+1  registered Gray-coded read pointer, sent to the write domain.
- `empty`  out  1  FIFO holds no words.
- `level`  out  ADDR_WIDTH+1  words available to read.
- `underflow`  out  1  one-cycle pulse when a read is requested while empty.
- `ptr_err`  out  1  sticky pointer-integrity error (see Configuration).

## Operation
- **Synchronizer:** `SYNC_STAGES` flops in series on `wr_ptr_gray_in`. The last stage is `wr_gray_s`. No logic is placed between stages.
- **Gray to binary:**
  - `wr_bin[MSB] = wr_gray_s[MSB]`.
  - For lower bits, `wr_bin[i] = wr_bin[i+1] ^ wr_gray_s[i]`.
  - The result is registered into `wr_ptr_bin`.
- **Read accept:** `rd_acc = rd_en & ~empty`.
  - On `rd_acc`, `rd_ptr_bin <= rd_ptr_bin + 1`, modulo 2^(ADDR_WIDTH+1), so the value wraps from all-ones to 0.
- **Gray output:** `rd_ptr_gray <= next_rd_ptr_bin ^ (next_rd_ptr_bin >> 1)`. It is always the Gray image of `rd_ptr_bin`, updated on the same edge.
- **Level:** `level = wr_ptr_bin - rd_ptr_bin`, computed modulo 2^(ADDR_WIDTH+1). It is combinational from registers and is never negative.
- **Empty:** `empty = (level == 0)`.
- **Underflow:** `underflow <= rd_en & empty`. In that case the pointer does not move.
- **Reset values:**
  - All synchronizer flops, `wr_ptr_bin`, `rd_ptr_bin` and `rd_ptr_gray` are 0.
  - `empty` = 1, `level` = 0, `underflow` = 0, `ptr_err` = 0.
  - `rd_addr` = 0.
- **Reset mid-operation:** asserting `rst_n` low clears all state immediately, without waiting for a clock edge. The pending read is discarded.

## Timing
- **Write-pointer latency:** a stable change on `wr_ptr_gray_in` is visible in `level`/`empty` after `SYNC_STAGES+1` rising edges. With the defaults this is 3 edges.
- **Read latency:** `rd_addr` is valid in the cycle `rd_acc` is high. The pointer advances at the end of that cycle. `rd_ptr_gray` changes on the same edge.
- **Back-to-back reads:** allowed every cycle while `empty` = 0.
- **Last word:** a read accepted at `level` = 1 drives `empty` to 1 on the next cycle. A `rd_en` held high in that next cycle gives `underflow` = 1 and no pointer move.
- **Simultaneous write arrival and read:** `level` reflects both changes on the same edge, because `wr_ptr_bin` increments and `rd_ptr_bin` increments independently.
- **Empty is pessimistic:** the write pointer is delayed by the synchronizer, so `empty` can be high while data actually exists. This is the required behaviour.

## Configuration
- **Macro:** `GRAY_PTR_RX_CHECK_EN`.
- **Defined:** `ptr_err` is set, and stays set until reset, under either of these conditions:
  - consecutive `wr_gray_s` values differ in more than one bit;
  - computed `level` exceeds 2^ADDR_WIDTH.
- **Undefined:** `ptr_err` is tied to 0 and no checker logic is synthesized.

## Test plan
All scenarios use `ADDR_WIDTH`=4 and `SYNC_STAGES`=2.
1. **Reset state:** hold `rst_n`=0 with `wr_ptr_gray_in`=5'h1F, then release. Require `empty`=1, `level`=0, `rd_ptr_gray`=0, and `underflow`=0 on all clocks during reset.
2. **Fill and drain:**
   - Step `wr_ptr_gray_in` through the Gray codes for 1..5, one per clock. Require `level`=5 three edges after the last step.
   - Assert `rd_en` for 5 cycles. Require `rd_addr` = 0,1,2,3,4, then `empty`=1. Require `rd_ptr_gray` = 5'h07 (the Gray code for 5).
3. **Underflow:** `rd_en`=1 while `empty`=1 gives `underflow`=1 for exactly one cycle per cycle requested, and `rd_ptr_bin` is unchanged.
4. **Wrap:**
   - Preload by streaming 30 writes and 30 reads.
   - Then write the pointer values 31, 0 and 1 and read 3 words.
   - Require `rd_ptr_bin` to pass through 31→0→1, `level` never to exceed 3, and `rd_addr` to follow 14,15,0.
5. **Async reset mid-stream:** drop `rst_n` at `level`=7, between clock edges. All outputs must reach their reset values before the next edge.
6. **Checker (`GRAY_PTR_RX_CHECK_EN`):** apply a jump from 5'h00 to 5'h03, which changes two bits. Require `ptr_err`=1 three edges later and held high until reset. Without the macro, `ptr_err` stays 0.
